// File: rtl/reservation_station.sv
// reservation_station: Tomasulo reservation station feeding one execution unit
// Ports: issue_* accepts an instruction with register-file operands,
// update_* renames the destination register to the allocated entry tag,
// result_* is the snooped result broadcast that fills operands and frees entries,
// and exec_* dispatches the lowest-index ready entry to the unit.
// Reset: rst is asynchronous and active-low.
module reservation_station #(
  parameter int DEPTH = 4,
  parameter int RS_ID_WIDTH = 5,
  parameter int RS_BASE_ID = 0,
  parameter int OP_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [OP_WIDTH-1:0]    issue_op,
  input  logic                   issue_src_valid [2],
  input  logic [31:0]            issue_src_value [2],
  input  logic [RS_ID_WIDTH-1:0] issue_src_rs_id [2],
  input  logic [4:0]             issue_dest_addr,
  output logic                   update_enable,
  output logic [4:0]             update_addr,
  output logic [RS_ID_WIDTH-1:0] update_rs_id,
  input  logic                   result_valid,
  input  logic [RS_ID_WIDTH-1:0] result_rs_id,
  input  logic [31:0]            result_value,
  output logic                   exec_valid,
  input  logic                   exec_ready,
  output logic [OP_WIDTH-1:0]    exec_op,
  output logic [31:0]            exec_op_a,
  output logic [31:0]            exec_op_b,
  output logic [4:0]             exec_dest_addr,
  output logic [RS_ID_WIDTH-1:0] exec_rs_id
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {FREE, WAITING, READY, EXECUTING} state_t;
  state_t st [DEPTH];
  logic [OP_WIDTH-1:0] op [DEPTH];
  logic [4:0] dest [DEPTH];
  logic [1:0] ov [DEPTH];
  logic [31:0] oval [DEPTH][2];
  logic [RS_ID_WIDTH-1:0] otag [DEPTH][2];
  logic [RS_ID_WIDTH-1:0] tag_of [DEPTH];
  logic free_any, rdy_any;
  logic [IW-1:0] alloc, sel;
  logic [1:0] iv;
  logic [31:0] ival [2];
  logic [1:0] nv [DEPTH];
  logic [31:0] nval [DEPTH][2];
  for (genvar g = 0; g < DEPTH; g++) begin : g_tag
    assign tag_of[g] = RS_ID_WIDTH'(RS_BASE_ID + g);
  end
  // Downward scan leaves the lowest matching index; iv/nv fold in a same-cycle broadcast.
  always_comb begin
    free_any = 1'b0;
    rdy_any = 1'b0;
    alloc = '0;
    sel = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (st[i] == FREE) begin
        free_any = 1'b1;
        alloc = IW'(i);
      end
      if (st[i] == READY) begin
        rdy_any = 1'b1;
        sel = IW'(i);
      end
    end
    for (int k = 0; k < 2; k++) begin
      iv[k] = issue_src_valid[k] || (result_valid && result_rs_id == issue_src_rs_id[k]);
      ival[k] = issue_src_valid[k] ? issue_src_value[k] : result_value;
      for (int i = 0; i < DEPTH; i++) begin
        nv[i][k] = ov[i][k] || (result_valid && result_rs_id == otag[i][k]);
        nval[i][k] = ov[i][k] ? oval[i][k] : result_value;
      end
    end
  end
  assign issue_ready = rst && free_any;
  assign update_enable = issue_valid && issue_ready;
  assign update_addr = rst ? issue_dest_addr : '0;
  assign update_rs_id = rst ? tag_of[alloc] : '0;
  assign exec_valid = rdy_any;
  assign exec_op = rdy_any ? op[sel] : '0;
  assign exec_op_a = rdy_any ? oval[sel][0] : '0;
  assign exec_op_b = rdy_any ? oval[sel][1] : '0;
  assign exec_dest_addr = rdy_any ? dest[sel] : '0;
  assign exec_rs_id = rdy_any ? tag_of[sel] : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        st[i] <= FREE;
        op[i] <= '0;
        dest[i] <= '0;
        ov[i] <= '0;
        for (int k = 0; k < 2; k++) begin
          oval[i][k] <= '0;
          otag[i][k] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (st[i] == FREE && update_enable && alloc == IW'(i)) begin
          st[i] <= &iv ? READY : WAITING;
          op[i] <= issue_op;
          dest[i] <= issue_dest_addr;
          ov[i] <= iv;
          for (int k = 0; k < 2; k++) begin
            oval[i][k] <= ival[k];
            otag[i][k] <= issue_src_rs_id[k];
          end
        end
        if (st[i] == WAITING) begin
          ov[i] <= nv[i];
          for (int k = 0; k < 2; k++) oval[i][k] <= nval[i][k];
          if (&nv[i]) st[i] <= READY;
        end
        if (st[i] == READY && exec_ready && sel == IW'(i)) st[i] <= EXECUTING;
        // The tag stays owned until its own result comes back, so it is never reissued early.
        if (st[i] == EXECUTING && result_valid && result_rs_id == tag_of[i]) st[i] <= FREE;
      end
    end
  end
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: scoreboard bench for reservation_station with a behavioural entry model
module tb_reservation_station;
  localparam int D = 4;
  localparam int W = 5;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  logic issue_valid, issue_ready, update_enable, result_valid, exec_valid, exec_ready;
  logic [7:0] issue_op, exec_op;
  logic issue_src_valid [2];
  logic [31:0] issue_src_value [2];
  logic [W-1:0] issue_src_rs_id [2];
  logic [4:0] issue_dest_addr, update_addr, exec_dest_addr;
  logic [W-1:0] update_rs_id, result_rs_id, exec_rs_id;
  logic [31:0] result_value, exec_op_a, exec_op_b;
  reservation_station dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_src_valid(issue_src_valid), .issue_src_value(issue_src_value),
    .issue_src_rs_id(issue_src_rs_id), .issue_dest_addr(issue_dest_addr),
    .update_enable(update_enable), .update_addr(update_addr), .update_rs_id(update_rs_id),
    .result_valid(result_valid), .result_rs_id(result_rs_id), .result_value(result_value),
    .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_op(exec_op), .exec_op_a(exec_op_a),
    .exec_op_b(exec_op_b), .exec_dest_addr(exec_dest_addr), .exec_rs_id(exec_rs_id)
  );
  // Model entry: st 0 free, 1 waiting for operands, 2 ready, 3 executing.
  typedef struct {
    int st;
    logic [7:0] op;
    logic [4:0] dest;
    bit v [2];
    logic [31:0] val [2];
    int tag [2];
  } ent_t;
  typedef struct {
    bit ir, ue, ev;
    int urs, ers;
    logic [4:0] ua, ed;
    logic [7:0] eop;
    logic [31:0] ea, eb;
  } exp_t;
  ent_t m [D];
  exp_t q [$];
  int checks = 0;
  int passes = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) $display("FAIL %s: got %h expected %h", n, a, e);
    else passes++;
  endtask
  // Reference model: predicts this cycle's outputs, then advances to the state after the coming edge.
  always @(negedge clk) begin : model
    exp_t e;
    ent_t n [D];
    int a, s;
    e = '{default: 0};
    if (!rst) begin
      for (int i = 0; i < D; i++) m[i].st = 0;
      q.push_back(e);
    end else begin
      a = -1;
      s = -1;
      for (int i = D - 1; i >= 0; i--) begin
        if (m[i].st == 0) a = i;
        if (m[i].st == 2) s = i;
      end
      e.ir = a >= 0;
      e.ue = issue_valid && e.ir;
      e.urs = a;
      e.ua = issue_dest_addr;
      e.ev = s >= 0;
      if (e.ev) begin
        e.eop = m[s].op;
        e.ea = m[s].val[0];
        e.eb = m[s].val[1];
        e.ed = m[s].dest;
        e.ers = s;
      end
      q.push_back(e);
      n = m;
      for (int i = 0; i < D; i++) begin
        if (m[i].st == 1) begin
          for (int k = 0; k < 2; k++)
            if (!n[i].v[k] && result_valid && int'(result_rs_id) == n[i].tag[k]) begin
              n[i].v[k] = 1;
              n[i].val[k] = result_value;
            end
          if (n[i].v[0] && n[i].v[1]) n[i].st = 2;
        end else if (m[i].st == 2) begin
          if (exec_ready && s == i) n[i].st = 3;
        end else if (m[i].st == 3) begin
          if (result_valid && int'(result_rs_id) == i) n[i].st = 0;
        end
      end
      if (e.ue) begin
        n[a].op = issue_op;
        n[a].dest = issue_dest_addr;
        for (int k = 0; k < 2; k++) begin
          n[a].tag[k] = int'(issue_src_rs_id[k]);
          if (issue_src_valid[k]) begin
            n[a].v[k] = 1;
            n[a].val[k] = issue_src_value[k];
          end else if (result_valid && result_rs_id == issue_src_rs_id[k]) begin
            n[a].v[k] = 1;
            n[a].val[k] = result_value;
          end else begin
            n[a].v[k] = 0;
            n[a].val[k] = 0;
          end
        end
        n[a].st = (n[a].v[0] && n[a].v[1]) ? 2 : 1;
      end
      m = n;
    end
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    #1;
    if (q.size() == 0) begin
      checks++;
      $display("FAIL scoreboard: no expected entry");
    end else begin
      e = q.pop_front();
      chk("issue_ready", 32'(issue_ready), 32'(e.ir));
      chk("update_enable", 32'(update_enable), 32'(e.ue));
      if (e.ue) begin
        chk("update_rs_id", 32'(update_rs_id), 32'(e.urs));
        chk("update_addr", 32'(update_addr), 32'(e.ua));
      end
      chk("exec_valid", 32'(exec_valid), 32'(e.ev));
      if (e.ev) begin
        chk("exec_rs_id", 32'(exec_rs_id), 32'(e.ers));
        chk("exec_op", 32'(exec_op), 32'(e.eop));
        chk("exec_op_a", exec_op_a, e.ea);
        chk("exec_op_b", exec_op_b, e.eb);
        chk("exec_dest_addr", 32'(exec_dest_addr), 32'(e.ed));
      end
    end
  end
  task automatic drv(bit iv, logic [7:0] o, bit v0, logic [31:0] d0, int t0, bit v1,
                     logic [31:0] d1, int t1, logic [4:0] da, bit rv, int rt,
                     logic [31:0] rval, bit er);
    @(posedge clk);
    #1;
    issue_valid = iv;
    issue_op = o;
    issue_src_valid[0] = v0;
    issue_src_value[0] = d0;
    issue_src_rs_id[0] = W'(t0);
    issue_src_valid[1] = v1;
    issue_src_value[1] = d1;
    issue_src_rs_id[1] = W'(t1);
    issue_dest_addr = da;
    result_valid = rv;
    result_rs_id = W'(rt);
    result_value = rval;
    exec_ready = er;
  endtask
  task automatic idle(int n, bit er);
    repeat (n) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, er);
  endtask
  task automatic drain();
    repeat (2) for (int t = 0; t < 8; t++) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, t, 32'h5a5a0000 + t, 1);
  endtask
  task automatic rnd();
    int ex [$];
    int rt;
    for (int i = 0; i < D; i++) if (m[i].st == 3) ex.push_back(i);
    rt = (ex.size() > 0 && $urandom_range(0, 1)) ? ex[$urandom_range(0, ex.size() - 1)] : $urandom_range(0, 7);
    drv($urandom_range(0, 9) < 6, 8'($urandom), $urandom_range(0, 1), $urandom, $urandom_range(0, 5),
        $urandom_range(0, 1), $urandom, $urandom_range(0, 5), 5'($urandom),
        $urandom_range(0, 1), rt, $urandom, $urandom_range(0, 1));
  endtask
  initial begin
    issue_valid = 0;
    issue_op = 0;
    for (int k = 0; k < 2; k++) begin
      issue_src_valid[k] = 0;
      issue_src_value[k] = 0;
      issue_src_rs_id[k] = 0;
    end
    issue_dest_addr = 0;
    result_valid = 0;
    result_rs_id = 0;
    result_value = 0;
    exec_ready = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    drv(1, 8'h11, 1, 5, 0, 1, 7, 0, 3, 0, 0, 0, 0);
    idle(1, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h77, 0);
    drv(1, 8'h22, 1, 1, 0, 0, 0, 2, 4, 0, 0, 0, 0);
    idle(1, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'hdeadbeef, 0);
    idle(2, 0);
    idle(1, 1);
    drain();
    drv(1, 8'h33, 0, 0, 1, 1, 4, 0, 5, 1, 1, 9, 0);
    idle(1, 0);
    drain();
    for (int i = 0; i < 5; i++) drv(1, 8'(8'h40 + i), 1, i, 0, 1, 10 * i, 0, 5'(i), 0, 0, 0, 0);
    idle(1, 1);
    idle(2, 0);
    drv(1, 8'h50, 1, 1, 0, 1, 2, 0, 9, 1, 0, 0, 0);
    drv(1, 8'h51, 1, 3, 0, 1, 4, 0, 10, 0, 0, 0, 0);
    drain();
    drv(1, 8'h60, 0, 0, 9, 1, 1, 0, 1, 0, 0, 0, 0);
    drv(1, 8'h61, 1, 2, 0, 1, 3, 0, 2, 0, 0, 0, 0);
    drv(1, 8'h62, 0, 0, 9, 1, 1, 0, 3, 0, 0, 0, 0);
    drv(1, 8'h63, 1, 4, 0, 1, 5, 0, 4, 0, 0, 0, 0);
    idle(2, 1);
    drain();
    drv(1, 8'h70, 1, 1, 0, 1, 1, 0, 1, 0, 0, 0, 0);
    drv(1, 8'h71, 0, 0, 6, 1, 1, 0, 2, 0, 0, 0, 0);
    drv(1, 8'h72, 1, 1, 0, 1, 1, 0, 3, 0, 0, 0, 0);
    drv(1, 8'h73, 1, 1, 0, 1, 1, 0, 3, 0, 0, 0, 1);
    #1 rst = 0;
    #1;
    chk("async issue_ready", 32'(issue_ready), 0);
    chk("async exec_valid", 32'(exec_valid), 0);
    chk("async update_enable", 32'(update_enable), 0);
    idle(1, 0);
    rst = 1;
    drv(1, 8'h80, 1, 8, 0, 1, 9, 0, 6, 0, 0, 0, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 32'h1234, 0);
    idle(2, 1);
    drain();
    repeat (1500) rnd();
    drain();
    idle(2, 0);
    @(negedge clk);
    #2;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
Tomasulo-style reservation station for one execution unit. It sits between issue logic and the execution unit, and drives the GP register file update port.
- Accepts an instruction together with its two source operands, as read from the register file read ports (valid/value/rs_id).
- Renames the destination register to its own entry ID.
- Snoops the result broadcast to capture missing operands.
- Dispatches ready entries and frees an entry when its own result is broadcast.

Parameters:
DEPTH, 4, number of entries (1..16)
RS_ID_WIDTH, 5, width of reservation-station tags; must match the register file
RS_BASE_ID, 0, tag of entry 0; entry i has tag RS_BASE_ID+i; RS_BASE_ID+DEPTH <= 2**RS_ID_WIDTH
OP_WIDTH, 8, opaque opcode/control width forwarded to the unit

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-low (asserted when 0)
issue_valid  in  1  instruction offered
issue_ready  out  1  a free entry exists
issue_op  in  OP_WIDTH  opcode
issue_src_valid[0:1]  in  1 each  operand value valid (register file read_value_valid)
issue_src_value[0:1]  in  32 each  operand value
issue_src_rs_id[0:1]  in  RS_ID_WIDTH each  producing tag when not valid
issue_dest_addr  in  5  destination GPR
update_enable  out  1  to register file update port
update_addr  out  5  = issue_dest_addr
update_rs_id  out  RS_ID_WIDTH  tag of the allocated entry
result_valid  in  1  result broadcast
result_rs_id  in  RS_ID_WIDTH  producer tag
result_value  in  32  result data
exec_valid  out  1  an entry is dispatched to the unit
exec_ready  in  1  unit accepts
exec_op  out  OP_WIDTH  opcode
exec_op_a  out  32  operand 0
exec_op_b  out  32  operand 1
exec_dest_addr  out  5  destination GPR
exec_rs_id  out  RS_ID_WIDTH  tag the unit must broadcast with its result

Behaviour:
- Per-entry state: FREE, WAITING, READY, EXECUTING. The entry stores op, dest_addr, and per operand {valid, value, tag}.
- Reset (rst=0, asynchronous):
  - all entries FREE, all stored fields 0
  - issue_ready=0, exec_valid=0, update_enable=0, all other outputs 0
  - reset mid-operation discards every entry; in-flight results arriving after reset are ignored (no EXECUTING match)
- issue_ready = rst && (any entry FREE). Issue is accepted when issue_valid && issue_ready; the lowest-index FREE entry is allocated.
- update_enable = issue_valid && issue_ready (combinational, same cycle).
  - update_addr = issue_dest_addr; update_rs_id = RS_BASE_ID + allocated index.
  - The register file commits it on the same edge.
- Operand capture at issue:
  - Operand valid if issue_src_valid.
  - Else valid if result_valid && result_rs_id == issue_src_rs_id in the same cycle; result_value is captured.
  - Else stored as waiting on issue_src_rs_id.
  - The allocated entry enters READY if both operands are valid after capture, otherwise WAITING.
- Snooping: every cycle, each WAITING entry operand with valid=0 and tag == result_rs_id (result_valid=1) captures result_value and sets valid.
  - A WAITING entry whose operands are all valid after that cycle's capture is READY next cycle.
  - Capture and transition are on the same edge; dispatch cannot occur until the entry is READY.
- Dispatch:
  - exec_valid = any READY entry; the lowest-index READY entry is selected.
  - exec_* are combinational from that entry; exec_rs_id is its tag.
  - On exec_valid && exec_ready the entry goes to EXECUTING.
  - While exec_ready=0, the selection holds stable unless a lower-index entry becomes READY.
- Completion: result_valid with result_rs_id equal to an EXECUTING entry's tag sets that entry FREE on the edge. The tag stays reserved until then, so tags are never duplicated.
- Tags outside RS_BASE_ID..RS_BASE_ID+DEPTH-1 only affect operand snooping.
- A freed entry is not reallocatable in the same cycle; issue_ready reflects current-cycle state only.
- Simultaneous events are independent, all on one edge: issue, dispatch of a different entry, snoop capture, and completion.
- Full: issue_ready=0; issue_valid is held off with no state change and update_enable=0.
- Empty: exec_valid=0.

Test Plan:
1. Reset, then issue op=0x11, src0 valid 5, src1 valid 7, dest 3 -> update_enable=1, update_addr=3, update_rs_id=0; next cycle exec_valid=1, op_a=5, op_b=7, exec_rs_id=0.
2. Issue with src1 invalid tag 2; result_valid tag 2 value 0xDEADBEEF two cycles later -> exec_valid=0 until the cycle after capture, then op_b=0xDEADBEEF.
3. Issue with src0 invalid tag 1 while result_valid tag 1 value 9 is broadcast in the same cycle -> entry READY next cycle, op_a=9.
4. Issue 4 instructions with exec_ready=0 -> tags 0,1,2,3; issue_ready=0 on the 5th. Accept one dispatch: tag 0 goes EXECUTING, issue_ready stays 0 until result_rs_id=0 is broadcast, then the next issue gets tag 0.
5. Two READY entries (tags 1,3), exec_ready=1 -> tag 1 dispatches, then tag 3 the next cycle.
6. Pull rst low asynchronously with 3 entries occupied -> issue_ready, exec_valid, update_enable are 0 immediately; after release, the first issue gets tag 0 and a result with tag 2 changes nothing.
